// File: rtl/pps_sequencer_if.sv
// rtl/pps_sequencer_if.sv - control and status bundle between PPS sequencer and its host
interface pps_sequencer_if;
  logic        i_tick_1us;
  logic        i_en;
  logic        i_arm;
  logic        i_sync;
  logic [31:0] i_width_us;
  logic        o_pps;
  logic        o_pps_start;
  logic        o_busy;
  logic        o_cfg_err;
  logic [31:0] o_sec_count;

  modport master (
    output i_tick_1us, i_en, i_arm, i_sync, i_width_us,
    input  o_pps, o_pps_start, o_busy, o_cfg_err, o_sec_count
  );

  modport slave (
    input  i_tick_1us, i_en, i_arm, i_sync, i_width_us,
    output o_pps, o_pps_start, o_busy, o_cfg_err, o_sec_count
  );
endinterface

// File: rtl/pps_sequencer.sv
// rtl/pps_sequencer.sv - turns 1 us tick strobes into a programmable-width pulse-per-second
module pps_sequencer #(
  parameter logic [31:0] TICKS_PER_SEC = 32'd1000000,
  parameter logic [31:0] PULSE_US      = 32'd70
) (
  input  logic            i_clk_25MHz,
  input  logic            i_rst,
  pps_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t      state, state_n;
  logic [31:0] phase, phase_n;
  logic [31:0] width, width_n;
  logic [31:0] sec_count, sec_count_n;
  logic        pps, pps_n;
  logic        pps_start, pps_start_n;
  logic        busy, busy_n;
  logic        cfg_err, cfg_err_n;
  logic        width_ok;

  assign width_ok = (bus.i_width_us >= 32'd1) && (bus.i_width_us <= TICKS_PER_SEC - 32'd1);

  always_ff @(posedge i_clk_25MHz) begin
    if (i_rst) begin
      state     <= IDLE;
      phase     <= 32'd0;
      width     <= PULSE_US;
      sec_count <= 32'd0;
      pps       <= 1'b0;
      pps_start <= 1'b0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      width     <= width_n;
      sec_count <= sec_count_n;
      pps       <= pps_n;
      pps_start <= pps_start_n;
      busy      <= busy_n;
      cfg_err   <= cfg_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    width_n     = width;
    sec_count_n = sec_count;
    pps_n       = pps;
    pps_start_n = 1'b0;
    cfg_err_n   = cfg_err;

    if (!bus.i_en) begin
      state_n = IDLE;
      pps_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_arm) begin
            width_n     = width_ok ? bus.i_width_us : PULSE_US;
            cfg_err_n   = !width_ok;
            sec_count_n = 32'd0;
            state_n     = ARMED;
          end
        end
        ARMED, RUN: begin
          // A tick coinciding with sync is dropped so the realigned second starts on the next one.
          if (bus.i_sync) begin
            state_n = ARMED;
            pps_n   = 1'b0;
            phase_n = 32'd0;
          end else if (bus.i_tick_1us) begin
            if (state == ARMED || phase == TICKS_PER_SEC - 32'd1) begin
              state_n     = RUN;
              phase_n     = 32'd0;
              pps_n       = 1'b1;
              pps_start_n = 1'b1;
              sec_count_n = sec_count + 32'd1;
            end else begin
              phase_n = phase + 32'd1;
              pps_n   = (phase + 32'd1) < width;
            end
          end
        end
        default: begin
          state_n = IDLE;
          pps_n   = 1'b0;
        end
      endcase
    end

    busy_n = (state_n != IDLE);
  end

  assign bus.o_pps       = pps;
  assign bus.o_pps_start = pps_start;
  assign bus.o_busy      = busy;
  assign bus.o_cfg_err   = cfg_err;
  assign bus.o_sec_count = sec_count;

endmodule

// File: tb/tb_pps_sequencer.sv
// tb/tb_pps_sequencer.sv - directed bench for pps_sequencer with a 10-tick second
module tb_pps_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pps_sequencer_if bus ();

  pps_sequencer #(.TICKS_PER_SEC(32'd10), .PULSE_US(32'd3)) dut (
    .i_clk_25MHz (clk),
    .i_rst       (rst),
    .bus         (bus)
  );

  always #20 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One tick followed by three quiet clocks; pos is the expected phase after each tick.
  task automatic run_ticks(input int n, input int first_pos, input int w, input string tag);
    int p;
    for (int i = 0; i < n; i++) begin
      p = (first_pos + i) % 10;
      bus.i_tick_1us = 1'b1;
      step();
      bus.i_tick_1us = 1'b0;
      chk({tag, " pps"}, {31'd0, bus.o_pps}, {31'd0, (p < w)});
      chk({tag, " start"}, {31'd0, bus.o_pps_start}, {31'd0, (p == 0)});
      for (int j = 0; j < 3; j++) begin
        step();
        chk({tag, " pps_hold"}, {31'd0, bus.o_pps}, {31'd0, (p < w)});
        chk({tag, " start_low"}, {31'd0, bus.o_pps_start}, 32'd0);
      end
    end
  endtask

  task automatic arm(input logic [31:0] w);
    bus.i_arm      = 1'b1;
    bus.i_width_us = w;
    step();
    bus.i_arm      = 1'b0;
  endtask

  initial begin
    bus.i_tick_1us = 1'b0;
    bus.i_en       = 1'b1;
    bus.i_arm      = 1'b0;
    bus.i_sync     = 1'b0;
    bus.i_width_us = 32'd0;

    step();
    chk("rst pps", {31'd0, bus.o_pps}, 32'd0);
    chk("rst start", {31'd0, bus.o_pps_start}, 32'd0);
    chk("rst busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst cfg_err", {31'd0, bus.o_cfg_err}, 32'd0);
    chk("rst sec", bus.o_sec_count, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle pps", {31'd0, bus.o_pps}, 32'd0);
      chk("idle busy", {31'd0, bus.o_busy}, 32'd0);
      chk("idle sec", bus.o_sec_count, 32'd0);
    end

    arm(32'd2);
    chk("arm2 busy", {31'd0, bus.o_busy}, 32'd1);
    chk("arm2 cfg_err", {31'd0, bus.o_cfg_err}, 32'd0);
    chk("arm2 pps", {31'd0, bus.o_pps}, 32'd0);
    run_ticks(25, 0, 2, "w2");
    chk("w2 sec", bus.o_sec_count, 32'd3);

    bus.i_en = 1'b0;
    step();
    bus.i_en = 1'b1;
    chk("dis busy", {31'd0, bus.o_busy}, 32'd0);
    chk("dis sec_hold", bus.o_sec_count, 32'd3);
    arm(32'd0);
    chk("w0 cfg_err", {31'd0, bus.o_cfg_err}, 32'd1);
    chk("w0 sec_clear", bus.o_sec_count, 32'd0);
    run_ticks(10, 0, 3, "w0");
    chk("w0 sec", bus.o_sec_count, 32'd1);

    bus.i_en = 1'b0;
    step();
    bus.i_en = 1'b1;
    arm(32'd10);
    chk("w10 cfg_err", {31'd0, bus.o_cfg_err}, 32'd1);
    run_ticks(16, 0, 3, "w10");
    chk("w10 sec", bus.o_sec_count, 32'd2);

    bus.i_sync = 1'b1;
    step();
    bus.i_sync = 1'b0;
    chk("sync pps", {31'd0, bus.o_pps}, 32'd0);
    chk("sync busy", {31'd0, bus.o_busy}, 32'd1);
    chk("sync sec", bus.o_sec_count, 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sync pps_low", {31'd0, bus.o_pps}, 32'd0);
    end
    run_ticks(12, 0, 3, "resync");
    chk("resync sec", bus.o_sec_count, 32'd4);

    bus.i_en = 1'b0;
    step();
    chk("en_off pps", {31'd0, bus.o_pps}, 32'd0);
    chk("en_off start", {31'd0, bus.o_pps_start}, 32'd0);
    chk("en_off busy", {31'd0, bus.o_busy}, 32'd0);
    chk("en_off sec", bus.o_sec_count, 32'd4);
    bus.i_en = 1'b1;
    run_ticks(3, 1, 0, "noarm");
    chk("noarm busy", {31'd0, bus.o_busy}, 32'd0);
    chk("noarm sec", bus.o_sec_count, 32'd4);

    arm(32'd9);
    chk("w9 cfg_err", {31'd0, bus.o_cfg_err}, 32'd0);
    chk("w9 sec", bus.o_sec_count, 32'd0);
    run_ticks(2, 0, 9, "w9");
    bus.i_sync     = 1'b1;
    bus.i_tick_1us = 1'b1;
    step();
    bus.i_sync     = 1'b0;
    bus.i_tick_1us = 1'b0;
    chk("synctick busy", {31'd0, bus.o_busy}, 32'd1);
    chk("synctick pps", {31'd0, bus.o_pps}, 32'd0);
    chk("synctick start", {31'd0, bus.o_pps_start}, 32'd0);
    chk("synctick sec", bus.o_sec_count, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("synctick pps_low", {31'd0, bus.o_pps}, 32'd0);
    end
    run_ticks(1, 0, 9, "after_sync");
    chk("after_sync sec", bus.o_sec_count, 32'd2);

    arm(32'd2);
    chk("arm_run busy", {31'd0, bus.o_busy}, 32'd1);
    chk("arm_run sec", bus.o_sec_count, 32'd2);
    chk("arm_run pps", {31'd0, bus.o_pps}, 32'd1);
    run_ticks(10, 1, 9, "arm_run");
    chk("arm_run sec_end", bus.o_sec_count, 32'd3);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_run pps", {31'd0, bus.o_pps}, 32'd0);
    chk("rst_run start", {31'd0, bus.o_pps_start}, 32'd0);
    chk("rst_run busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_run cfg_err", {31'd0, bus.o_cfg_err}, 32'd0);
    chk("rst_run sec", bus.o_sec_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pps_sequencer.md
Name: pps_sequencer

Overview:
- Sequences the 1 us tick strobe from the free-running microsecond timer into a pulse-per-second output with programmable width (default 70 us).
- Handles arm, re-synchronisation and enable.
- Sits between the timer (configured for a 1 us period) and the PPS output pin.
- Counts emitted seconds for status readout.

Parameters:
- TICKS_PER_SEC, 1000000, tick strobes per PPS period.
- PULSE_US, 70, default and fallback pulse width in ticks.

Ports:
- i_clk_25MHz  input  1  system clock, 25 MHz.
- i_rst  input  1  synchronous reset, active-high.
- i_tick_1us  input  1  one-cycle strobe from timer, one per microsecond.
- i_en  input  1  level enable; low forces IDLE.
- i_arm  input  1  one-cycle request: latch width, start sequencing.
- i_sync  input  1  one-cycle request: abort current second, realign to next tick.
- i_width_us  input  32  requested pulse width in ticks, sampled on accepted i_arm.
- o_pps  output  1  registered PPS output.
- o_pps_start  output  1  one-cycle strobe coincident with each o_pps rising edge.
- o_busy  output  1  high in any state except IDLE.
- o_cfg_err  output  1  sticky: last accepted arm carried an invalid width.
- o_sec_count  output  32  number of pulses started since last arm, wraps 2^32-1 -> 0.

Behaviour:
- Reset: state=IDLE; o_pps=0, o_pps_start=0, o_busy=0, o_cfg_err=0, o_sec_count=0; width register=PULSE_US; phase counter=0.
- States: IDLE, ARMED, RUN. All outputs registered.
- Event priority, highest first: i_rst, then !i_en, then i_sync, then i_arm, then i_tick_1us.
- !i_en in any state: next cycle IDLE, o_pps=0, o_pps_start=0. o_sec_count and o_cfg_err hold.
- IDLE, i_en=1 and i_arm=1:
  - Width valid (1 <= i_width_us <= TICKS_PER_SEC-1): latch it, o_cfg_err<=0.
  - Otherwise: latch PULSE_US, o_cfg_err<=1.
  - In both cases: o_sec_count<=0, state<=ARMED.
- i_arm outside IDLE: ignored. i_sync in IDLE: ignored.
- ARMED: waits for i_tick_1us. On a tick:
  - state<=RUN, phase<=0, o_pps<=1, o_pps_start<=1, o_sec_count+=1.
  - Latency: o_pps rises one clock after the tick cycle.
- RUN, per i_tick_1us:
  - phase==TICKS_PER_SEC-1: phase<=0, o_pps<=1, o_pps_start<=1, o_sec_count+=1.
  - Else: phase<=phase+1; o_pps<=(phase+1 < width); o_pps_start<=0.
- RUN, no tick: all outputs hold, except o_pps_start, which is 0 in every cycle not directly following a start tick.
- Pulse timing:
  - o_pps is high for exactly `width` tick intervals.
  - It rises one clock after tick N and falls one clock after tick N+width.
  - Consecutive rising edges are exactly TICKS_PER_SEC ticks apart.
- i_sync in ARMED or RUN:
  - next cycle state=ARMED, o_pps=0, phase=0.
  - o_sec_count holds; width holds.
  - A tick in the same cycle as i_sync is discarded.
- i_tick_1us is at most one cycle wide; a tick held high for k cycles counts as k ticks (no edge detection).
- Comparisons are unsigned. The phase counter is 32 bits. Width 0 is invalid: a zero-width pulse is never produced.
- o_busy = (state != IDLE), registered.

Test Plan (TICKS_PER_SEC=10, PULSE_US=3, tick every 4 clocks unless noted):
- Reset then idle: i_en=1, no arm, 50 clocks -> o_pps=0, o_busy=0, o_sec_count=0 throughout.
- Arm with i_width_us=2, run 25 ticks:
  - o_pps rises one clock after 1st tick, high 8 clocks.
  - Period 40 clocks; o_pps_start is 1 clock wide at each rise.
  - o_sec_count=3 after 25 ticks.
- Arm with i_width_us=0, then again with i_width_us=10 -> o_cfg_err=1 each time; pulse width 3 ticks (12 clocks).
- i_sync at phase 5 of second 2 -> o_pps stays 0; next tick starts a pulse; o_sec_count goes 2->3; next period is the full 10 ticks.
- Deassert i_en mid-pulse (phase 1) -> o_pps=0 next clock, state IDLE, o_sec_count holds. Reassert i_en without arm -> no pulse.
- Simultaneous events:
  - i_sync and i_tick_1us in the same cycle -> tick dropped, state ARMED.
  - i_arm while in RUN -> ignored; width unchanged.
  - i_rst in RUN -> all outputs 0 the next clock.
